// File: rtl/uart_bridge_axi.sv
// Bridge that polls a source UART over AXI-Lite, buffers each received byte, and writes it to a sink UART's TX register.
// Optional frame-marker tracking on frame_toggle is built when UART_BRIDGE_SENTINEL_EN is defined.
module uart_bridge_axi #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RX_OFS     = 'h0,
  parameter int unsigned TX_OFS     = 'h4,
  parameter int unsigned STAT_OFS   = 'h8,
  parameter logic [7:0]  SENTINEL   = 8'h24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [ADDR_W-1:0]             AR_addr_SRC,
  output logic                          AR_valid_SRC,
  input  logic                          AR_ready_SRC,
  input  logic [31:0]                   R_data_SRC,
  input  logic                          R_valid_SRC,
  output logic                          R_ready_SRC,
  output logic [ADDR_W-1:0]             AR_addr_SNK,
  output logic                          AR_valid_SNK,
  input  logic                          AR_ready_SNK,
  input  logic [31:0]                   R_data_SNK,
  input  logic                          R_valid_SNK,
  output logic                          R_ready_SNK,
  output logic [ADDR_W-1:0]             AW_addr_SNK,
  output logic                          AW_valid_SNK,
  input  logic                          AW_ready_SNK,
  output logic [31:0]                   W_data_SNK,
  output logic                          W_valid_SNK,
  input  logic                          W_ready_SNK,
  input  logic [1:0]                    B_resp_SNK,
  input  logic                          B_valid_SNK,
  output logic                          B_ready_SNK,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    err_cnt,
  output logic                          frame_toggle,
  output logic [1:0]                    dbg_src_state,
  output logic [2:0]                    dbg_snk_state
);
  // valid/ready: a transfer happens on a rising edge where both are high; a valid
  // stays high with its address/data stable until that edge, then drops.

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RX_A   = ADDR_W'(RX_OFS);
  localparam logic [ADDR_W-1:0] TX_A   = ADDR_W'(TX_OFS);
  localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(STAT_OFS);

  typedef enum logic [1:0] {SRC_STAT, SRC_WSTAT, SRC_RD, SRC_WRD} src_state_e;
  typedef enum logic [2:0] {SNK_IDLE, SNK_STAT, SNK_WSTAT, SNK_WR, SNK_RESP} snk_state_e;

  src_state_e src_q, src_d;
  snk_state_e snk_q, snk_d;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count;
  logic             push, pop, full, empty;
  logic [7:0]       head;

  logic src_r_hs, snk_ar_hs, snk_r_hs, aw_hs, w_hs, b_hs;
  logic              src_ar_valid_d, snk_ar_valid_d, aw_valid_d, w_valid_d;
  logic [ADDR_W-1:0] src_ar_addr_d, snk_ar_addr_d, aw_addr_d;
  logic [31:0]       w_data_d;
  logic              aw_done_q, w_done_q, aw_done_d, w_done_d;

  assign full  = (count == LVL_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign fifo_level = count;

  assign src_r_hs  = R_valid_SRC && R_ready_SRC;
  assign snk_ar_hs = AR_valid_SNK && AR_ready_SNK;
  assign snk_r_hs  = R_valid_SNK && R_ready_SNK;
  assign aw_hs     = AW_valid_SNK && AW_ready_SNK;
  assign w_hs      = W_valid_SNK && W_ready_SNK;
  assign b_hs      = B_valid_SNK && B_ready_SNK;

  assign R_ready_SRC = (src_q == SRC_WSTAT) || (src_q == SRC_WRD);
  assign R_ready_SNK = (snk_q == SNK_WSTAT);
  assign B_ready_SNK = (snk_q == SNK_RESP);
  assign push = (src_q == SRC_WRD) && src_r_hs;
  assign pop  = (snk_q == SNK_RESP) && b_hs;

  assign dbg_src_state = src_q;
  assign dbg_snk_state = snk_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= R_data_SRC[7:0];
  end

  // Pointers are PTR_W wide, so they wrap modulo the power-of-two depth on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Address phase raises valid one cycle after entering a read state.
  always_comb begin
    src_d          = src_q;
    src_ar_valid_d = AR_valid_SRC;
    src_ar_addr_d  = AR_addr_SRC;
    case (src_q)
      SRC_STAT, SRC_RD: begin
        if (!AR_valid_SRC) begin
          src_ar_valid_d = 1'b1;
          src_ar_addr_d  = (src_q == SRC_STAT) ? STAT_A : RX_A;
        end else if (AR_ready_SRC) begin
          src_ar_valid_d = 1'b0;
          src_d          = (src_q == SRC_STAT) ? SRC_WSTAT : SRC_WRD;
        end
      end
      SRC_WSTAT: if (src_r_hs) src_d = (R_data_SRC[0] && !full) ? SRC_RD : SRC_STAT;
      SRC_WRD:   if (src_r_hs) src_d = SRC_STAT;
      default:   src_d = SRC_STAT;
    endcase
  end

  always_comb begin
    snk_d          = snk_q;
    snk_ar_valid_d = AR_valid_SNK;
    snk_ar_addr_d  = AR_addr_SNK;
    aw_valid_d     = AW_valid_SNK;
    aw_addr_d      = AW_addr_SNK;
    w_valid_d      = W_valid_SNK;
    w_data_d       = W_data_SNK;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    case (snk_q)
      SNK_IDLE: begin
        if (!empty) begin
          snk_d          = SNK_STAT;
          snk_ar_valid_d = 1'b1;
          snk_ar_addr_d  = STAT_A;
        end
      end
      SNK_STAT: begin
        if (snk_ar_hs) begin
          snk_ar_valid_d = 1'b0;
          snk_d          = SNK_WSTAT;
        end
      end
      SNK_WSTAT: begin
        if (snk_r_hs) begin
          if (R_data_SNK[3]) begin
            snk_d          = SNK_STAT;
            snk_ar_valid_d = 1'b1;
            snk_ar_addr_d  = STAT_A;
          end else begin
            snk_d      = SNK_WR;
            aw_valid_d = 1'b1;
            aw_addr_d  = TX_A;
            w_valid_d  = 1'b1;
            w_data_d   = {24'b0, head};
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
          end
        end
      end
      SNK_WR: begin
        if (aw_hs) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_hs) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) snk_d = SNK_RESP;
      end
      SNK_RESP: if (b_hs) snk_d = SNK_IDLE;
      default:  snk_d = SNK_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q        <= SRC_STAT;
      snk_q        <= SNK_IDLE;
      AR_valid_SRC <= 1'b0;
      AR_addr_SRC  <= '0;
      AR_valid_SNK <= 1'b0;
      AR_addr_SNK  <= '0;
      AW_valid_SNK <= 1'b0;
      AW_addr_SNK  <= '0;
      W_valid_SNK  <= 1'b0;
      W_data_SNK   <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      src_q        <= src_d;
      snk_q        <= snk_d;
      AR_valid_SRC <= src_ar_valid_d;
      AR_addr_SRC  <= src_ar_addr_d;
      AR_valid_SNK <= snk_ar_valid_d;
      AR_addr_SNK  <= snk_ar_addr_d;
      AW_valid_SNK <= aw_valid_d;
      AW_addr_SNK  <= aw_addr_d;
      W_valid_SNK  <= w_valid_d;
      W_data_SNK   <= w_data_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                err_cnt <= '0;
    else if (pop && (B_resp_SNK != 2'b00) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 1'b1;
  end

`ifdef UART_BRIDGE_SENTINEL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        frame_toggle <= 1'b0;
    else if (pop && (head == SENTINEL)) frame_toggle <= ~frame_toggle;
  end
`else
  logic [7:0] unused_sentinel;
  assign unused_sentinel = SENTINEL;
  assign frame_toggle = 1'b0;
`endif

  // Only the status flags and the RX byte of the read data are meaningful here.
  logic unused_rdata;
  assign unused_rdata = ^{R_data_SRC[31:8], R_data_SNK[31:4], R_data_SNK[2:0]};

endmodule

// File: tb/tb_uart_bridge_axi.sv
// Directed bench for uart_bridge_axi: AXI-Lite UART slave models on both sides and a byte scoreboard.
// Build with UART_BRIDGE_SENTINEL_EN defined to also exercise frame_toggle.
`timescale 1ns/1ps
module tb_uart_bridge_axi;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] AR_addr_SRC, AR_addr_SNK, AW_addr_SNK;
  logic AR_valid_SRC, AR_ready_SRC, R_valid_SRC, R_ready_SRC;
  logic [31:0] R_data_SRC, R_data_SNK, W_data_SNK;
  logic AR_valid_SNK, AR_ready_SNK, R_valid_SNK, R_ready_SNK;
  logic AW_valid_SNK, AW_ready_SNK, W_valid_SNK, W_ready_SNK;
  logic [1:0] B_resp_SNK;
  logic B_valid_SNK, B_ready_SNK;
  logic [4:0] fifo_level;
  logic [7:0] err_cnt;
  logic frame_toggle;
  logic [1:0] dbg_src_state;
  logic [2:0] dbg_snk_state;

  uart_bridge_axi dut (
    .clk(clk), .rst_n(rst_n),
    .AR_addr_SRC(AR_addr_SRC), .AR_valid_SRC(AR_valid_SRC), .AR_ready_SRC(AR_ready_SRC),
    .R_data_SRC(R_data_SRC), .R_valid_SRC(R_valid_SRC), .R_ready_SRC(R_ready_SRC),
    .AR_addr_SNK(AR_addr_SNK), .AR_valid_SNK(AR_valid_SNK), .AR_ready_SNK(AR_ready_SNK),
    .R_data_SNK(R_data_SNK), .R_valid_SNK(R_valid_SNK), .R_ready_SNK(R_ready_SNK),
    .AW_addr_SNK(AW_addr_SNK), .AW_valid_SNK(AW_valid_SNK), .AW_ready_SNK(AW_ready_SNK),
    .W_data_SNK(W_data_SNK), .W_valid_SNK(W_valid_SNK), .W_ready_SNK(W_ready_SNK),
    .B_resp_SNK(B_resp_SNK), .B_valid_SNK(B_valid_SNK), .B_ready_SNK(B_ready_SNK),
    .fifo_level(fifo_level), .err_cnt(err_cnt), .frame_toggle(frame_toggle),
    .dbg_src_state(dbg_src_state), .dbg_snk_state(dbg_snk_state)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] src_bytes[$];
  int src_stat_rd = 0, src_rx_rd = 0, snk_writes = 0, snk_b_cnt = 0;
  logic snk_full = 1'b0;
  int aw_delay = 0, w_delay = 0;
  logic [1:0] bresp = 2'b00;
  logic aw_first_seen = 1'b0;
  logic toggle_model = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Source UART: STAT bit0 = byte available, RX pops the next byte into the scoreboard.
  initial begin : src_slave
    logic ar_hs, r_hs, prev_stall;
    logic [ADDR_W-1:0] ar_a, prev_addr;
    AR_ready_SRC = 1'b0; R_valid_SRC = 1'b0; R_data_SRC = '0;
    prev_stall = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && rst_n) begin
        check("ar_src_hold_valid", AR_valid_SRC, 1);
        check("ar_src_hold_addr", AR_addr_SRC, prev_addr);
      end
      prev_stall = AR_valid_SRC && !AR_ready_SRC;
      prev_addr  = AR_addr_SRC;
      ar_hs = AR_valid_SRC && AR_ready_SRC;
      ar_a  = AR_addr_SRC;
      r_hs  = R_valid_SRC && R_ready_SRC;
      @(posedge clk); #1;
      if (!rst_n) begin
        AR_ready_SRC = 1'b0; R_valid_SRC = 1'b0; R_data_SRC = '0; prev_stall = 1'b0;
      end else begin
        if (r_hs) R_valid_SRC = 1'b0;
        if (ar_hs) begin
          R_valid_SRC = 1'b1;
          if (ar_a == 4'h8) begin
            src_stat_rd++;
            R_data_SRC = {31'b0, (src_bytes.size() != 0)};
          end else begin
            src_rx_rd++;
            if (src_bytes.size() != 0) begin
              R_data_SRC = {24'b0, src_bytes[0]};
              exp_q.push_back(src_bytes.pop_front());
            end else begin
              R_data_SRC = 32'h0000_00EE;
            end
          end
        end
        AR_ready_SRC = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Sink UART: STAT bit3 = TX full, checks each TX write against the scoreboard.
  initial begin : snk_slave
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_got, w_got;
    int aw_cnt, w_cnt;
    logic [7:0] last_byte, e;
    AR_ready_SNK = 1'b0; R_valid_SNK = 1'b0; R_data_SNK = '0;
    AW_ready_SNK = 1'b0; W_ready_SNK = 1'b0; B_valid_SNK = 1'b0; B_resp_SNK = 2'b00;
    aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0; last_byte = '0;
    forever begin
      @(negedge clk);
      ar_hs = AR_valid_SNK && AR_ready_SNK;
      r_hs  = R_valid_SNK && R_ready_SNK;
      aw_hs = AW_valid_SNK && AW_ready_SNK;
      w_hs  = W_valid_SNK && W_ready_SNK;
      b_hs  = B_valid_SNK && B_ready_SNK;
      if (!AW_valid_SNK && W_valid_SNK) aw_first_seen = 1'b1;
      if (aw_hs) check("aw_addr", AW_addr_SNK, 32'h4);
      if (w_hs) begin
        check("w_expected_avail", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("w_data", W_data_SNK, {24'b0, e});
        end
        last_byte = W_data_SNK[7:0];
      end
      @(posedge clk); #1;
      if (!rst_n) begin
        AR_ready_SNK = 1'b0; R_valid_SNK = 1'b0; AW_ready_SNK = 1'b0; W_ready_SNK = 1'b0;
        B_valid_SNK = 1'b0; aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0;
        toggle_model = 1'b0;
      end else begin
        AR_ready_SNK = 1'b1;
        if (r_hs) R_valid_SNK = 1'b0;
        if (ar_hs) begin
          R_valid_SNK = 1'b1;
          R_data_SNK  = {28'b0, snk_full, 3'b0};
        end
        if (aw_hs) aw_got = 1'b1;
        if (w_hs)  w_got  = 1'b1;
        if (b_hs) begin
          B_valid_SNK = 1'b0;
          snk_b_cnt++;
`ifdef UART_BRIDGE_SENTINEL_EN
          if (last_byte == 8'h24) toggle_model = ~toggle_model;
`endif
          check("frame_toggle", frame_toggle, toggle_model);
        end
        if (aw_got && w_got && !B_valid_SNK) begin
          B_valid_SNK = 1'b1; B_resp_SNK = bresp;
          aw_got = 1'b0; w_got = 1'b0;
          snk_writes++;
        end
        aw_cnt = AW_valid_SNK ? aw_cnt + 1 : 0;
        w_cnt  = W_valid_SNK ? w_cnt + 1 : 0;
        AW_ready_SNK = AW_valid_SNK && (aw_cnt > aw_delay);
        W_ready_SNK  = W_valid_SNK && (w_cnt > w_delay);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic seen;
    int base, rx_before, stat_before;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ar_valid_src", AR_valid_SRC, 0);
    check("rst_r_ready_src", R_ready_SRC, 0);
    check("rst_ar_valid_snk", AR_valid_SNK, 0);
    check("rst_r_ready_snk", R_ready_SNK, 0);
    check("rst_aw_valid", AW_valid_SNK, 0);
    check("rst_w_valid", W_valid_SNK, 0);
    check("rst_b_ready", B_ready_SNK, 0);
    check("rst_ar_addr_src", AR_addr_SRC, 0);
    check("rst_aw_addr", AW_addr_SNK, 0);
    check("rst_w_data", W_data_SNK, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_frame_toggle", frame_toggle, 0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin @(posedge clk); #1; if (AR_valid_SRC) seen = 1'b1; end
    check("ar_src_after_reset", seen, 1);

    // Single byte: held in the FIFO while the sink reports TX full, then written.
    snk_full = 1'b1;
    src_bytes.push_back(8'h41);
    for (int i = 0; i < 200 && fifo_level != 1; i++) @(negedge clk);
    check("single_level_one", fifo_level, 1);
    repeat (20) @(negedge clk);
    check("single_level_hold", fifo_level, 1);
    check("single_no_write_full", snk_writes, 0);
    snk_full = 1'b0;
    for (int i = 0; i < 200 && snk_b_cnt != 1; i++) @(negedge clk);
    check("single_write_count", snk_writes, 1);
    check("single_level_zero", fifo_level, 0);

    // Fill to 16 with the sink blocked; a 17th byte must stay in the source.
    snk_full = 1'b1;
    for (int i = 0; i < 17; i++) src_bytes.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 2000 && fifo_level != 16; i++) @(negedge clk);
    check("full_level_16", fifo_level, 16);
    rx_before = src_rx_rd; stat_before = src_stat_rd;
    repeat (40) @(negedge clk);
    check("full_no_rx_reads", src_rx_rd, rx_before);
    check("full_stat_reads_continue", (src_stat_rd > stat_before), 1);
    check("full_byte_left_in_src", src_bytes.size(), 1);
    check("full_level_still_16", fifo_level, 16);
    snk_full = 1'b0;
    for (int i = 0; i < 3000 && !(snk_b_cnt == 18 && fifo_level == 0); i++) @(negedge clk);
    check("drain_b_count", snk_b_cnt, 18);
    check("drain_level", fifo_level, 0);
    check("drain_scoreboard_empty", exp_q.size(), 0);

    // AW accepted two cycles before W.
    aw_delay = 0; w_delay = 2; aw_first_seen = 1'b0;
    src_bytes.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 300 && snk_b_cnt != 19; i++) @(negedge clk);
    check("split_aw_first", aw_first_seen, 1);
    repeat (20) @(negedge clk);
    check("split_one_write", snk_b_cnt, 19);
    check("split_level", fifo_level, 0);
    w_delay = 0;

    // Error responses: every byte still popped once.
    bresp = 2'b10;
    for (int i = 0; i < 3; i++) src_bytes.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 500 && snk_b_cnt != 22; i++) @(negedge clk);
    check("err_b_count", snk_b_cnt, 22);
    check("err_cnt_three", err_cnt, 3);
    check("err_level", fifo_level, 0);
    check("err_scoreboard_empty", exp_q.size(), 0);
    bresp = 2'b00;

    // Frame markers "$GP$".
    src_bytes.push_back(8'h24); src_bytes.push_back(8'h47);
    src_bytes.push_back(8'h50); src_bytes.push_back(8'h24);
    for (int i = 0; i < 600 && snk_b_cnt != 26; i++) @(negedge clk);
    check("frame_b_count", snk_b_cnt, 26);
    check("frame_toggle_final", frame_toggle, 0);
    check("frame_err_unchanged", err_cnt, 3);

    // Reset while the sink write is outstanding.
    aw_delay = 50; w_delay = 50;
    src_bytes.push_back(8'($urandom_range(0, 255)));
    src_bytes.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 500 && dbg_snk_state != 3'd3; i++) @(negedge clk);
    check("mid_wr_aw_valid", AW_valid_SNK, 1);
    check("mid_wr_w_valid", W_valid_SNK, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_aw_valid", AW_valid_SNK, 0);
    check("mid_rst_w_valid", W_valid_SNK, 0);
    check("mid_rst_ar_valid_src", AR_valid_SRC, 0);
    check("mid_rst_ar_valid_snk", AR_valid_SNK, 0);
    check("mid_rst_b_ready", B_ready_SNK, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    check("mid_rst_frame_toggle", frame_toggle, 0);
    exp_q.delete();
    src_bytes.delete();
    aw_delay = 0; w_delay = 0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin @(posedge clk); #1; if (AR_valid_SRC) seen = 1'b1; end
    check("ar_src_after_mid_reset", seen, 1);
    base = snk_b_cnt;
    src_bytes.push_back(8'h5A);
    for (int i = 0; i < 300 && snk_b_cnt != base + 1; i++) @(negedge clk);
    check("post_rst_write", snk_b_cnt, base + 1);
    check("post_rst_level", fifo_level, 0);
    check("post_rst_scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_bridge_axi.md
UART_BRIDGE_AXI -- requirements
Module: uart_bridge_axi

Interface
REQ-001 Parameter ADDR_W, default 4: AXI-Lite address width, both ports.
REQ-002 Parameter FIFO_DEPTH, default 16: byte FIFO depth; SHALL be a power of two, at least 2.
REQ-003 Parameter RX_OFS/TX_OFS/STAT_OFS, defaults 'h0/'h4/'h8: UART register offsets.
REQ-004 Parameter SENTINEL, default 8'h24: frame-start byte.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 AR_addr_SRC/AR_valid_SRC/AR_ready_SRC  out/out/in  ADDR_W/1/1  source UART read address.
REQ-008 R_data_SRC/R_valid_SRC/R_ready_SRC  in/in/out  32/1/1  source UART read data.
REQ-009 AR_addr_SNK/AR_valid_SNK/AR_ready_SNK, R_data_SNK/R_valid_SNK/R_ready_SNK  same as REQ-007/008  sink UART reads.
REQ-010 AW_addr_SNK/AW_valid_SNK/AW_ready_SNK  out/out/in  ADDR_W/1/1  sink write address.
REQ-011 W_data_SNK/W_valid_SNK/W_ready_SNK  out/out/in  32/1/1  sink write data.
REQ-012 B_resp_SNK/B_valid_SNK/B_ready_SNK  in/in/out  2/1/1  sink write response.
REQ-013 fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes buffered.
REQ-014 err_cnt  out  8  count of non-OKAY B_resp_SNK, saturating at 255.
REQ-015 frame_toggle  out  1  toggles once per forwarded SENTINEL byte.

Function
REQ-016 Source FSM SHALL run SRC_STAT -> SRC_WSTAT -> SRC_RD -> SRC_WRD -> SRC_STAT.
REQ-017 SRC_STAT SHALL issue a read of STAT_OFS; SRC_RD SHALL issue a read of RX_OFS.
REQ-018 AR_valid SHALL assert on the cycle after entry into SRC_STAT or SRC_RD.
REQ-019 AR_valid and AR_addr SHALL then hold stable until the AR_ready handshake completes.
REQ-020 R_ready SHALL be high only in the wait states (SRC_WSTAT, SRC_WRD).
REQ-021 SRC_WSTAT on R handshake: go to SRC_RD if R_data[0]=1 and FIFO not full, else back to SRC_STAT.
REQ-022 SRC_WRD on R handshake SHALL push R_data[7:0] into the FIFO, then go to SRC_STAT.
REQ-023 Sink FSM SHALL run SNK_IDLE -> SNK_STAT -> SNK_WSTAT -> SNK_WR -> SNK_RESP -> SNK_IDLE.
REQ-024 SNK_IDLE SHALL stay while the FIFO is empty.
REQ-025 SNK_STAT SHALL read STAT_OFS.
REQ-026 SNK_WSTAT SHALL return to SNK_STAT if R_data[3]=1 (TX full), else go to SNK_WR.
REQ-027 SNK_WR SHALL drive AW_addr=TX_OFS and W_data={24'b0, FIFO head}, asserting AW_valid and W_valid together.
REQ-028 In SNK_WR each valid SHALL drop independently on its own handshake; the FSM SHALL leave SNK_WR when both handshakes are complete.
REQ-029 SNK_RESP SHALL hold B_ready=1; on B handshake it SHALL pop the FIFO head, increment err_cnt if B_resp!=0, and go to SNK_IDLE.
REQ-030 A byte SHALL be popped exactly once, even on error; there is no retry.
REQ-031 Simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 No byte SHALL ever be dropped: the full condition blocks source reads (REQ-021).
REQ-034 Byte order on the sink SHALL equal arrival order on the source.
REQ-035 Source AW/W/B channels do not exist; the block never writes the source UART.

Reset
REQ-036 rst_n low SHALL immediately force: both FSMs to their first states (SRC_STAT, SNK_IDLE), all valid/ready outputs 0, all addresses and data 0, FIFO empty, fifo_level=0, err_cnt=0, frame_toggle=0.
REQ-037 Reset mid-transaction SHALL abandon the transaction; buffered bytes are lost.
REQ-038 After rst_n rises, the first AR_valid_SRC SHALL assert within 2 cycles.

Configuration
REQ-039 Macro UART_BRIDGE_SENTINEL_EN defined: frame_toggle SHALL invert on each B handshake whose popped byte equals SENTINEL.
REQ-040 Macro UART_BRIDGE_SENTINEL_EN undefined: frame_toggle SHALL be constant 0 and no comparator SHALL be built.

Verification
REQ-041 Source STAT=1 then RX=8'h41, sink STAT=0 -> one sink write, addr 4, data 32'h41, fifo_level 1->0.
REQ-042 Push 16 bytes with sink STAT=8 held -> fifo_level=16, source issues only STAT reads, no RX reads, no data loss after release.
REQ-043 Sink AW_ready two cycles before W_ready -> AW_valid drops first, W_valid holds, exactly one write completes.
REQ-044 B_resp=2'b10 on three writes -> err_cnt=3, all three bytes popped.
REQ-045 With UART_BRIDGE_SENTINEL_EN, stream "$GP$" -> frame_toggle 0->1->0.
REQ-046 rst_n low mid SNK_WR -> all valids 0 same cycle, fifo_level=0.
